// File: rtl/piso_frame_serializer.sv
// piso_frame_serializer
//
// Parallel-in / serial-out frame serializer that feeds the serial inputs of
// the universal shift register. Words arrive on a valid/ready handshake into
// a one-entry buffer, are moved into a shift register, and leave one bit per
// shift_en tick. A buffered word is reloaded on the tick that consumes the
// last bit of the current frame, so back-to-back words stream with no gap.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous, active-low reset (0 = reset asserted)
//   in_valid     upstream word valid
//   in_data      upstream word, N bits
//   in_ready     buffer can accept a word (register-derived only)
//   shift_en     bit-rate tick; current bit is consumed on an edge where it is 1
//   sout         serial data bit
//   sout_valid   sout carries a frame bit
//   frame_start  current sout is the first bit of a frame
//   done         current sout is the last bit and is consumed this cycle
//   busy         frame in progress or word buffered
//
// Parameters:
//   N            data word width in bits (N >= 2)
//   MSB_FIRST    0 = bit 0 transmitted first, 1 = bit N-1 transmitted first

module piso_frame_serializer #(
  parameter int N         = 4,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  input  logic [N-1:0] in_data,
  output logic         in_ready,
  input  logic         shift_en,
  output logic         sout,
  output logic         sout_valid,
  output logic         frame_start,
  output logic         done,
  output logic         busy
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e         state_q, state_d;
  logic [N-1:0]   sreg_q, sreg_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N-1:0]   buf_data_q, buf_data_d;
  logic           buf_full_q, buf_full_d;

  logic [N-1:0]   sreg_shifted;
  logic           accept;

  // The shift always moves bits toward whichever end drives sout, so the
  // next bit to send is always sitting at the output end.
  always_comb begin
    if (MSB_FIRST) begin
      sreg_shifted = {sreg_q[N-2:0], 1'b0};
    end else begin
      sreg_shifted = {1'b0, sreg_q[N-1:1]};
    end
  end

  // in_ready depends on the buffer flag only, keeping upstream free of any
  // combinational path through this block.
  assign accept = in_valid && !buf_full_q;

  // State register: all storage, cleared asynchronously so a partial frame
  // is dropped immediately and never resumes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      sreg_q     <= '0;
      cnt_q      <= '0;
      buf_data_q <= '0;
      buf_full_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sreg_q     <= sreg_d;
      cnt_q      <= cnt_d;
      buf_data_q <= buf_data_d;
      buf_full_q <= buf_full_d;
    end
  end

  // Next-state logic. Accepting a word and draining the buffer can never
  // happen on the same edge (one needs the buffer empty, the other full),
  // so the accept update below never collides with a drain.
  always_comb begin
    state_d    = state_q;
    sreg_d     = sreg_q;
    cnt_d      = cnt_q;
    buf_data_d = buf_data_q;
    buf_full_d = buf_full_q;

    unique case (state_q)
      IDLE: begin
        if (buf_full_q) begin
          sreg_d     = buf_data_q;
          buf_full_d = 1'b0;
          cnt_d      = '0;
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        if (shift_en) begin
          if (cnt_q != LAST) begin
            sreg_d = sreg_shifted;
            cnt_d  = cnt_q + CW'(1);
          end else if (buf_full_q) begin
            // Reload on the last tick so the next frame follows with no gap.
            sreg_d     = buf_data_q;
            buf_full_d = 1'b0;
            cnt_d      = '0;
          end else begin
            sreg_d  = '0;
            cnt_d   = '0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (accept) begin
      buf_data_d = in_data;
      buf_full_d = 1'b1;
    end
  end

  // Output logic. Frame qualifiers are only meaningful while shifting;
  // everything frame-related is forced low in IDLE.
  always_comb begin
    sout        = 1'b0;
    sout_valid  = 1'b0;
    frame_start = 1'b0;
    done        = 1'b0;
    if (state_q == SHIFT) begin
      sout        = MSB_FIRST ? sreg_q[N-1] : sreg_q[0];
      sout_valid  = 1'b1;
      frame_start = (cnt_q == '0);
      done        = shift_en && (cnt_q == LAST);
    end
    busy     = (state_q == SHIFT) || buf_full_q;
    in_ready = !buf_full_q;
  end

endmodule

// File: tb/tb_piso_frame_serializer.sv
// tb_piso_frame_serializer
//
// Drives two serializers (LSB-first and MSB-first, N=4) with identical
// stimulus. A behavioural model tracks, per instance, whether a frame is
// active, which word is being sent and which bit position is on the line,
// plus the one-entry buffer; every cycle the DUT outputs are compared
// against it. Directed scenarios additionally pin the observed bit streams
// to hand-written literals.

module tb_piso_frame_serializer;

  localparam int N = 4;

  logic         clk;
  logic         rst;
  logic         inValid;
  logic [N-1:0] inData;
  logic         shiftEn;

  logic inReady0, sout0, soutValid0, frameStart0, done0, busy0;
  logic inReady1, sout1, soutValid1, frameStart1, done1, busy1;

  int checks;
  int passes;

  // Behavioural model state, index 0 = LSB-first, 1 = MSB-first.
  bit           mActive  [2];
  logic [N-1:0] mWord    [2];
  int           mPos     [2];
  bit           mBufFull [2];
  logic [N-1:0] mBuf     [2];

  // Observed streams and pulse counters, used by the directed scenarios.
  bit strm0[$];
  bit strm1[$];
  int fsCnt   [2];
  int doneCnt [2];
  int runLen  [2];
  int maxRun  [2];

  piso_frame_serializer #(.N(N), .MSB_FIRST(1'b0)) dut0 (
    .clk         (clk),
    .reset       (rst),
    .in_valid    (inValid),
    .in_data     (inData),
    .in_ready    (inReady0),
    .shift_en    (shiftEn),
    .sout        (sout0),
    .sout_valid  (soutValid0),
    .frame_start (frameStart0),
    .done        (done0),
    .busy        (busy0)
  );

  piso_frame_serializer #(.N(N), .MSB_FIRST(1'b1)) dut1 (
    .clk         (clk),
    .reset       (rst),
    .in_valid    (inValid),
    .in_data     (inData),
    .in_ready    (inReady1),
    .shift_en    (shiftEn),
    .sout        (sout1),
    .sout_valid  (soutValid1),
    .frame_start (frameStart1),
    .done        (done1),
    .busy        (busy1)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, act, exp, $time);
    end else begin
      passes++;
    end
  endtask

  // Model update: a frame takes the buffered word when idle, advances one
  // bit position per tick, and on the last tick either picks up the next
  // buffered word or goes idle. A word is accepted whenever the buffer is empty.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < 2; k++) begin
        mActive[k]  <= 1'b0;
        mWord[k]    <= '0;
        mPos[k]     <= 0;
        mBufFull[k] <= 1'b0;
        mBuf[k]     <= '0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (!mActive[k]) begin
          if (mBufFull[k]) begin
            mActive[k]  <= 1'b1;
            mWord[k]    <= mBuf[k];
            mPos[k]     <= 0;
            mBufFull[k] <= 1'b0;
          end
        end else if (shiftEn) begin
          if (mPos[k] < N - 1) begin
            mPos[k] <= mPos[k] + 1;
          end else if (mBufFull[k]) begin
            mWord[k]    <= mBuf[k];
            mPos[k]     <= 0;
            mBufFull[k] <= 1'b0;
          end else begin
            mActive[k] <= 1'b0;
          end
        end
        if (inValid && !mBufFull[k]) begin
          mBuf[k]     <= inData;
          mBufFull[k] <= 1'b1;
        end
      end
    end
  end

  // Expected {in_ready, sout, sout_valid, frame_start, done, busy}.
  function automatic logic [5:0] expVec(input int k);
    logic b;
    int   idx;
    b = 1'b0;
    if (mActive[k]) begin
      idx = (k == 1) ? (N - 1 - mPos[k]) : mPos[k];
      b   = mWord[k][idx];
    end
    return {!mBufFull[k], b, mActive[k], mActive[k] && (mPos[k] == 0),
            mActive[k] && shiftEn && (mPos[k] == N - 1), mActive[k] || mBufFull[k]};
  endfunction

  // Per-cycle compare on the falling edge, away from the active edge, plus
  // recording of the streams and pulses seen on the line.
  always @(negedge clk) begin
    checkOutput("dut0_cycle", {26'd0, inReady0, sout0, soutValid0, frameStart0, done0, busy0}, {26'd0, expVec(0)});
    checkOutput("dut1_cycle", {26'd0, inReady1, sout1, soutValid1, frameStart1, done1, busy1}, {26'd0, expVec(1)});
    if (soutValid0) begin
      strm0.push_back(sout0);
      runLen[0] = runLen[0] + 1;
      if (runLen[0] > maxRun[0]) maxRun[0] = runLen[0];
    end else begin
      runLen[0] = 0;
    end
    if (soutValid1) begin
      strm1.push_back(sout1);
      runLen[1] = runLen[1] + 1;
      if (runLen[1] > maxRun[1]) maxRun[1] = runLen[1];
    end else begin
      runLen[1] = 0;
    end
    if (frameStart0) fsCnt[0] = fsCnt[0] + 1;
    if (frameStart1) fsCnt[1] = fsCnt[1] + 1;
    if (done0) doneCnt[0] = doneCnt[0] + 1;
    if (done1) doneCnt[1] = doneCnt[1] + 1;
  end

  task automatic clearLogs();
    strm0.delete();
    strm1.delete();
    for (int k = 0; k < 2; k++) begin
      fsCnt[k]   = 0;
      doneCnt[k] = 0;
      runLen[k]  = 0;
      maxRun[k]  = 0;
    end
  endtask

  // Stream packed in transmit order: first bit on the line is the leftmost.
  function automatic logic [31:0] packQ(input int k);
    logic [31:0] v;
    v = '0;
    if (k == 0) begin
      foreach (strm0[i]) v = (v << 1) | 32'(strm0[i]);
    end else begin
      foreach (strm1[i]) v = (v << 1) | 32'(strm1[i]);
    end
    return v;
  endfunction

  // One cycle of stimulus: inputs change just after a rising edge; acc
  // reports whether the word was taken on the following edge.
  task automatic step(input bit v, input logic [N-1:0] d, input bit se, output bit acc);
    inValid = v;
    inData  = d;
    shiftEn = se;
    @(negedge clk);
    acc = v && inReady0 && rst;
    @(posedge clk);
    #1;
  endtask

  // Present n words in order, each held until accepted, shift_en held high.
  task automatic applyStimulus(input logic [N-1:0] w [3], input int n, input int cycles);
    int idx;
    bit acc;
    idx = 0;
    for (int c = 0; c < cycles; c++) begin
      if (idx < n) begin
        step(1'b1, w[idx], 1'b1, acc);
        if (acc) idx++;
      end else begin
        step(1'b0, '0, 1'b1, acc);
      end
    end
  endtask

  initial begin
    logic [N-1:0] words [3];
    bit           acc;
    bit           v;
    logic [N-1:0] d;

    checks  = 0;
    passes  = 0;
    rst     = 1'b0;
    inValid = 1'b1;
    inData  = 4'b1011;
    shiftEn = 1'b1;
    clearLogs();

    // Reset held with in_valid high: nothing accepted, idle outputs.
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_outputs0", {27'd0, inReady0, sout0, soutValid0, busy0, done0}, 32'b10000);
    checkOutput("reset_outputs1", {27'd0, inReady1, sout1, soutValid1, busy1, done1}, 32'b10000);
    inValid = 1'b0;
    rst     = 1'b1;
    clearLogs();
    repeat (3) step(1'b0, '0, 1'b1, acc);
    checkOutput("reset_no_accept_busy", {31'd0, busy0}, 32'd0);
    checkOutput("reset_no_accept_bits", strm0.size(), 32'd0);

    // Single word 1011, LSB first: 1,1,0,1.
    clearLogs();
    words[0] = 4'b1011;
    applyStimulus(words, 1, 8);
    checkOutput("single_bits", packQ(0), 32'b1101);
    checkOutput("single_len", strm0.size(), 32'd4);
    checkOutput("single_frame_start", fsCnt[0], 32'd1);
    checkOutput("single_done", doneCnt[0], 32'd1);
    checkOutput("single_idle_after", {30'd0, soutValid0, busy0}, 32'd0);
    checkOutput("single_msb_bits", packQ(1), 32'b1011);

    // Back-to-back 1011, 0110: eight contiguous bits.
    clearLogs();
    words[0] = 4'b1011;
    words[1] = 4'b0110;
    applyStimulus(words, 2, 14);
    checkOutput("b2b_bits", packQ(0), 32'b11010110);
    checkOutput("b2b_len", strm0.size(), 32'd8);
    checkOutput("b2b_contiguous", maxRun[0], 32'd8);
    checkOutput("b2b_frame_start", fsCnt[0], 32'd2);

    // Backpressure with three words.
    clearLogs();
    words[0] = 4'b1011;
    words[1] = 4'b0110;
    words[2] = 4'b1111;
    applyStimulus(words, 3, 20);
    checkOutput("bp_bits", packQ(0), 32'b110101101111);
    checkOutput("bp_len", strm0.size(), 32'd12);
    checkOutput("bp_contiguous", maxRun[0], 32'd12);
    checkOutput("bp_done", doneCnt[0], 32'd3);

    // Tick every other cycle, word 0011: each bit held two cycles.
    clearLogs();
    for (int i = 0; i < 12; i++) begin
      step(i == 0, 4'b0011, (i >= 2) && (i % 2 == 1), acc);
    end
    checkOutput("gap_bits", packQ(0), 32'b11110000);
    checkOutput("gap_len", strm0.size(), 32'd8);
    checkOutput("gap_done", doneCnt[0], 32'd1);

    // Reset mid-frame, then resend on the MSB-first instance.
    clearLogs();
    step(1'b1, 4'b1000, 1'b1, acc);
    step(1'b0, '0, 1'b1, acc);
    step(1'b0, '0, 1'b1, acc);
    step(1'b0, '0, 1'b1, acc);
    #1;
    rst = 1'b0;
    #1;
    checkOutput("midreset_clear1", {26'd0, inReady1, sout1, soutValid1, frameStart1, done1, busy1}, 32'b100000);
    checkOutput("midreset_clear0", {26'd0, inReady0, sout0, soutValid0, frameStart0, done0, busy0}, 32'b100000);
    @(posedge clk);
    #1;
    rst = 1'b1;
    clearLogs();
    words[0] = 4'b1000;
    applyStimulus(words, 1, 8);
    checkOutput("midreset_msb_bits", packQ(1), 32'b1000);
    checkOutput("midreset_msb_len", strm1.size(), 32'd4);
    checkOutput("midreset_lsb_bits", packQ(0), 32'b0001);

    // Randomized traffic, data held stable until accepted.
    v = 1'b0;
    d = '0;
    for (int c = 0; c < 1500; c++) begin
      if (!v || acc) begin
        v = ($urandom_range(0, 9) < 6);
        d = N'($urandom);
      end
      step(v, d, ($urandom_range(0, 9) < 7), acc);
      if (!v) acc = 1'b0;
    end
    repeat (20) step(1'b0, '0, 1'b1, acc);
    checkOutput("random_drained", {30'd0, busy0, busy1}, 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
